// File: rtl/uart_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_wb_arbiter_if
// Bundles the signals between N_REQ wishbone requesters, the arbiter, and the
// single UART register-file wishbone slave (3-bit address, 8-bit data).
//
// Parameters:
//   N_REQ     number of requesting masters
//
// Requester side:
//   req_cyc/req_stb/req_we [N_REQ]   per-requester wishbone control
//   req_addr [3*N_REQ]               requester i at [3i+2:3i]
//   req_data [8*N_REQ]               requester i at [8i+7:8i]
//   req_ack/req_err [N_REQ]          ack/err routed to the granted requester
//   rd_data [8]                      slave read data, broadcast
//   gnt [N_REQ]                      one-hot grant, zero when idle
// UART slave side:
//   wb_cyc_o/wb_stb_o/wb_we_o/wb_addr_o/wb_data_o   to the slave
//   wb_data_i/wb_ack_i                               from the slave
//
// Modports:
//   master  the arbiter's view (it masters the UART slave)
//   slave   the environment's view (requesters plus UART slave model)
// -----------------------------------------------------------------------------
interface uart_wb_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]   req_cyc;
    logic [N_REQ-1:0]   req_stb;
    logic [N_REQ-1:0]   req_we;
    logic [3*N_REQ-1:0] req_addr;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ack;
    logic [N_REQ-1:0]   req_err;
    logic [7:0]         rd_data;
    logic [N_REQ-1:0]   gnt;

    logic               wb_cyc_o;
    logic               wb_stb_o;
    logic               wb_we_o;
    logic [2:0]         wb_addr_o;
    logic [7:0]         wb_data_o;
    logic [7:0]         wb_data_i;
    logic               wb_ack_i;

    modport master (
        input  req_cyc, req_stb, req_we, req_addr, req_data, wb_data_i, wb_ack_i,
        output req_ack, req_err, rd_data, gnt,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o
    );

    modport slave (
        output req_cyc, req_stb, req_we, req_addr, req_data, wb_data_i, wb_ack_i,
        input  req_ack, req_err, rd_data, gnt,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o
    );
endinterface

// File: rtl/uart_wb_arbiter.sv
// -----------------------------------------------------------------------------
// uart_wb_arbiter
// Round-robin arbiter sharing the UART register-file wishbone slave between
// N_REQ masters. A grant is held for the whole cyc window so read-modify-write
// sequences on LC/IE are atomic. FSM: IDLE -> BUSY -> RELEASE -> IDLE.
//
// Ports:
//   clk    clock
//   rstn   asynchronous active-low reset
//   bus    uart_wb_arbiter_if.master (requester and UART slave signals)
//
// Optional feature (macro UART_ARB_TIMEOUT_EN):
//   stalled-ack watchdog; after TIMEOUT_CYCLES stalled cycles the granted
//   requester gets a one-cycle req_err pulse and the grant is released.
//   Without the macro req_err is tied to 0 and a missing ack holds the grant.
// -----------------------------------------------------------------------------
module uart_wb_arbiter #(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    uart_wb_arbiter_if.master     bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    // Last granted index; while BUSY it is also the current grant index.
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [N_REQ-1:0]   req_s;
    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               timeout_s;

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("uart_wb_arbiter: N_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_wb_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    assign req_s = bus.req_cyc & bus.req_stb;

    // Round-robin pick: first active request searching upward from rr+1 with wrap.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!pick_found_s && req_s[(int'(rr_q) + k) % N_REQ]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = IDX_W'((int'(rr_q) + k) % N_REQ);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Stall counter: cleared outside BUSY and on ack, counts stalled strobes.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_s = 1'b0;
        if (state_q == ST_BUSY) begin
            if (bus.wb_ack_i) begin
                cnt_d = '0;
            end else if (req_s[rr_q]) begin
                // The cycle that would make the count reach TIMEOUT_CYCLES aborts.
                if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_s = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic: grant from IDLE, hold while cyc, one RELEASE cycle.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d = ST_BUSY;
                    gnt_d   = ONE_HOT0 << pick_idx_s;
                    rr_d    = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (timeout_s || !bus.req_cyc[rr_q]) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            rr_q    <= IDX_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

    // Slave-side mux and ack/err routing; everything is zero outside BUSY.
    always_comb begin
        bus.wb_cyc_o  = 1'b0;
        bus.wb_stb_o  = 1'b0;
        bus.wb_we_o   = 1'b0;
        bus.wb_addr_o = 3'd0;
        bus.wb_data_o = 8'd0;
        bus.req_ack   = '0;
        bus.req_err   = '0;
        if (state_q == ST_BUSY) begin
            // Combinational path so a requester dropping cyc aborts in the same cycle.
            bus.wb_cyc_o        = bus.req_cyc[rr_q] & ~timeout_s;
            bus.wb_stb_o        = bus.req_stb[rr_q] & ~timeout_s;
            bus.wb_we_o         = bus.req_we[rr_q];
            bus.wb_addr_o       = bus.req_addr[int'(rr_q) * 3 +: 3];
            bus.wb_data_o       = bus.req_data[int'(rr_q) * 8 +: 8];
            bus.req_ack[rr_q]   = bus.wb_ack_i;
            bus.req_err[rr_q]   = timeout_s;
        end else begin
            bus.wb_cyc_o = 1'b0;
        end
    end

    assign bus.rd_data = bus.wb_data_i;
    assign bus.gnt     = gnt_q;
endmodule

// File: tb/tb_uart_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_wb_arbiter
// Self-checking bench for uart_wb_arbiter (N_REQ=3, TIMEOUT_CYCLES=4).
// Inputs change 1 ns after the rising edge and are checked 1-2 ns later;
// acknowledged slave transfers are compared at the falling edge against a
// queue of expected transfers pushed as stimulus is driven.
// -----------------------------------------------------------------------------
module tb_uart_wb_arbiter;
    localparam int N  = 3;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int         idx;
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
    } xfer_t;

    xfer_t          exp_q[$];
    xfer_t          mon_e;
    logic [N-1:0]   mon_oh;

    always #5 clk = ~clk;

    uart_wb_arbiter_if #(.N_REQ(N)) bus ();

    uart_wb_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic c, input logic s, input logic w,
                           input logic [2:0] a, input logic [7:0] d);
        bus.req_cyc[i]         = c;
        bus.req_stb[i]         = s;
        bus.req_we[i]          = w;
        bus.req_addr[3*i +: 3] = a;
        bus.req_data[8*i +: 8] = d;
    endtask

    task automatic push(input int i, input logic w, input logic [2:0] a, input logic [7:0] d);
        xfer_t e;
        e.idx = i; e.we = w; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every acknowledged slave transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (rstn && bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got we=%b addr=%0d data=%h gnt=%b exp=none",
                         bus.wb_we_o, bus.wb_addr_o, bus.wb_data_o, bus.gnt);
            end else begin
                mon_e = exp_q.pop_front();
                mon_oh = '0;
                mon_oh[mon_e.idx] = 1'b1;
                if (bus.wb_we_o !== mon_e.we || bus.wb_addr_o !== mon_e.addr ||
                    bus.wb_data_o !== mon_e.data || bus.gnt !== mon_oh || bus.req_ack !== mon_oh) begin
                    errors++;
                    $display("FAIL sb_xfer got we=%b addr=%0d data=%h gnt=%b ack=%b exp we=%b addr=%0d data=%h gnt/ack=%b",
                             bus.wb_we_o, bus.wb_addr_o, bus.wb_data_o, bus.gnt, bus.req_ack,
                             mon_e.we, mon_e.addr, mon_e.data, mon_oh);
                end
            end
        end
    end

    task automatic test_reset();
        #2;
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt got=%b exp=%b", bus.gnt, 3'b000); end
        checks++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus.wb_we_o !== 1'b0) begin
            errors++; $display("FAIL rst_wb_ctl got=%b%b%b exp=000", bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o); end
        checks++; if (bus.wb_addr_o !== 3'd0 || bus.wb_data_o !== 8'd0) begin
            errors++; $display("FAIL rst_wb_bus got=%0d/%h exp=0/00", bus.wb_addr_o, bus.wb_data_o); end
        checks++; if (bus.req_ack !== 3'b000 || bus.req_err !== 3'b000) begin
            errors++; $display("FAIL rst_ack_err got=%b/%b exp=000/000", bus.req_ack, bus.req_err); end
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 1'b1, 1'b1, 3'd3, 8'h83);
        bus.wb_data_i = 8'h5A;
        #1;
        checks++; if (bus.wb_stb_o !== 1'b0 || bus.gnt !== 3'b000) begin
            errors++; $display("FAIL sw_latency got stb=%b gnt=%b exp stb=0 gnt=000", bus.wb_stb_o, bus.gnt); end
        step();
        checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL sw_gnt got=%b exp=%b", bus.gnt, 3'b001); end
        checks++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_stb_o !== 1'b1 || bus.wb_we_o !== 1'b1) begin
            errors++; $display("FAIL sw_ctl got=%b%b%b exp=111", bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o); end
        checks++; if (bus.wb_addr_o !== 3'd3 || bus.wb_data_o !== 8'h83) begin
            errors++; $display("FAIL sw_bus got=%0d/%h exp=3/83", bus.wb_addr_o, bus.wb_data_o); end
        checks++; if (bus.req_ack !== 3'b000) begin errors++; $display("FAIL sw_noack got=%b exp=000", bus.req_ack); end
        push(0, 1'b1, 3'd3, 8'h83);
        bus.wb_ack_i = 1'b1;
        #1;
        checks++; if (bus.req_ack !== 3'b001) begin errors++; $display("FAIL sw_ack got=%b exp=001", bus.req_ack); end
        checks++; if (bus.rd_data !== 8'h5A) begin errors++; $display("FAIL sw_rd got=%h exp=5a", bus.rd_data); end
        step();
        bus.wb_ack_i = 1'b0;
        set_req(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        #1;
        checks++; if (bus.wb_cyc_o !== 1'b0 || bus.gnt !== 3'b001) begin
            errors++; $display("FAIL sw_drop got cyc=%b gnt=%b exp cyc=0 gnt=001", bus.wb_cyc_o, bus.gnt); end
        step();
        checks++; if (bus.gnt !== 3'b000 || bus.wb_cyc_o !== 1'b0) begin
            errors++; $display("FAIL sw_release got gnt=%b cyc=%b exp 000/0", bus.gnt, bus.wb_cyc_o); end
        step();
    endtask

    task automatic test_rmw();
        set_req(0, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00);
        step();
        checks++; if (bus.gnt !== 3'b001 || bus.wb_we_o !== 1'b0) begin
            errors++; $display("FAIL rmw_rd_gnt got gnt=%b we=%b exp 001/0", bus.gnt, bus.wb_we_o); end
        set_req(1, 1'b1, 1'b1, 1'b1, 3'd5, 8'h11);
        bus.wb_data_i = 8'h03;
        bus.wb_ack_i  = 1'b1;
        push(0, 1'b0, 3'd3, 8'h00);
        #1;
        checks++; if (bus.req_ack !== 3'b001 || bus.rd_data !== 8'h03) begin
            errors++; $display("FAIL rmw_rd got ack=%b rd=%h exp 001/03", bus.req_ack, bus.rd_data); end
        step();
        bus.wb_ack_i = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00);
        #1;
        checks++; if (bus.wb_stb_o !== 1'b0 || bus.wb_cyc_o !== 1'b1 || bus.gnt !== 3'b001) begin
            errors++; $display("FAIL rmw_gap got stb=%b cyc=%b gnt=%b exp 0/1/001", bus.wb_stb_o, bus.wb_cyc_o, bus.gnt); end
        step();
        set_req(0, 1'b1, 1'b1, 1'b1, 3'd3, 8'h83);
        push(0, 1'b1, 3'd3, 8'h83);
        bus.wb_ack_i = 1'b1;
        #1;
        checks++; if (bus.gnt !== 3'b001 || bus.wb_data_o !== 8'h83 || bus.req_ack !== 3'b001) begin
            errors++; $display("FAIL rmw_wr got gnt=%b data=%h ack=%b exp 001/83/001", bus.gnt, bus.wb_data_o, bus.req_ack); end
        step();
        bus.wb_ack_i = 1'b0;
        set_req(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        #1;
        checks++; if (bus.wb_cyc_o !== 1'b0 || bus.gnt !== 3'b001) begin
            errors++; $display("FAIL rmw_drop got cyc=%b gnt=%b exp 0/001", bus.wb_cyc_o, bus.gnt); end
        step();
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL rmw_release got=%b exp=000", bus.gnt); end
        step();
        checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL rmw_idle got=%b exp=000", bus.gnt); end
        step();
        checks++; if (bus.gnt !== 3'b010 || bus.wb_addr_o !== 3'd5) begin
            errors++; $display("FAIL rmw_next got gnt=%b addr=%0d exp 010/5", bus.gnt, bus.wb_addr_o); end
        push(1, 1'b1, 3'd5, 8'h11);
        bus.wb_ack_i = 1'b1;
        step();
        bus.wb_ack_i = 1'b0;
        set_req(1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
        step();
    endtask

    task automatic test_stray_ack();
        bus.wb_ack_i = 1'b1;
        #1;
        checks++; if (bus.req_ack !== 3'b000 || bus.wb_cyc_o !== 1'b0) begin
            errors++; $display("FAIL stray_ack got ack=%b cyc=%b exp 000/0", bus.req_ack, bus.wb_cyc_o); end
        step();
        checks++; if (bus.gnt !== 3'b000 || bus.req_ack !== 3'b000) begin
            errors++; $display("FAIL stray_state got gnt=%b ack=%b exp 000/000", bus.gnt, bus.req_ack); end
        bus.wb_ack_i = 1'b0;
        set_req(2, 1'b1, 1'b1, 1'b1, 3'd1, 8'hC7);
        step();
        checks++; if (bus.gnt !== 3'b100) begin errors++; $display("FAIL stray_next got=%b exp=100", bus.gnt); end
        push(2, 1'b1, 3'd1, 8'hC7);
        bus.wb_ack_i = 1'b1;
        step();
        bus.wb_ack_i = 1'b0;
        set_req(2, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
        step();
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b1, 1'b1, 1'b1, 3'd2, 8'h44);
        step();
        checks++; if (bus.gnt !== 3'b001 || bus.wb_stb_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_busy got gnt=%b stb=%b exp 001/1", bus.gnt, bus.wb_stb_o); end
        #1;
        rstn = 1'b0;
        #1;
        checks++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus.gnt !== 3'b000) begin
            errors++; $display("FAIL rstmid_async got cyc=%b stb=%b gnt=%b exp 0/0/000", bus.wb_cyc_o, bus.wb_stb_o, bus.gnt); end
        set_req(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        set_req(2, 1'b1, 1'b1, 1'b0, 3'd6, 8'h00);
        step();
        rstn = 1'b1;
        step();
        checks++; if (bus.gnt !== 3'b100 || bus.wb_addr_o !== 3'd6) begin
            errors++; $display("FAIL rstmid_regrant got gnt=%b addr=%0d exp 100/6", bus.gnt, bus.wb_addr_o); end
        push(2, 1'b0, 3'd6, 8'h00);
        bus.wb_ack_i = 1'b1;
        step();
        bus.wb_ack_i = 1'b0;
        set_req(2, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
        step();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] oh;
        int           e;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 1'b1, 3'(i + 1), 8'h20 + 8'(i));
        for (int k = 0; k < 4; k++) begin
            e = k % N;
            oh = '0;
            oh[e] = 1'b1;
            step();
            checks++; if (bus.gnt !== oh) begin errors++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, bus.gnt, oh); end
            push(e, 1'b1, 3'(e + 1), 8'h20 + 8'(e));
            bus.wb_ack_i = 1'b1;
            step();
            bus.wb_ack_i = 1'b0;
            set_req(e, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
            step();
            set_req(e, 1'b1, 1'b1, 1'b1, 3'(e + 1), 8'h20 + 8'(e));
            checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL rr_release%0d got=%b exp=000", k, bus.gnt); end
            step();
            checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL rr_idle%0d got=%b exp=000", k, bus.gnt); end
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        set_req(1, 1'b1, 1'b1, 1'b1, 3'd7, 8'h99);
        set_req(2, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00);
        step();
        checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL to_gnt got=%b exp=010", bus.gnt); end
        for (int c = 1; c < TO; c++) begin
            checks++; if (bus.req_err !== 3'b000 || bus.wb_stb_o !== 1'b1) begin
                errors++; $display("FAIL to_stall%0d got err=%b stb=%b exp 000/1", c, bus.req_err, bus.wb_stb_o); end
            step();
        end
        checks++; if (bus.req_err !== 3'b010 || bus.wb_stb_o !== 1'b0 || bus.wb_cyc_o !== 1'b0) begin
            errors++; $display("FAIL to_err got err=%b stb=%b cyc=%b exp 010/0/0", bus.req_err, bus.wb_stb_o, bus.wb_cyc_o); end
        step();
        set_req(1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        checks++; if (bus.gnt !== 3'b000 || bus.req_err !== 3'b000) begin
            errors++; $display("FAIL to_release got gnt=%b err=%b exp 000/000", bus.gnt, bus.req_err); end
        step();
        step();
        checks++; if (bus.gnt !== 3'b100) begin errors++; $display("FAIL to_next got=%b exp=100", bus.gnt); end
        push(2, 1'b0, 3'd1, 8'h00);
        bus.wb_ack_i = 1'b1;
        step();
        bus.wb_ack_i = 1'b0;
        set_req(2, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
        step();
    endtask
`endif

    initial begin
        rstn          = 1'b0;
        bus.req_cyc   = '0;
        bus.req_stb   = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.wb_data_i = 8'h00;
        bus.wb_ack_i  = 1'b0;
        test_reset();
        test_single_write();
        test_rmw();
        test_stray_ack();
        test_reset_mid();
        test_round_robin();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
